// File: rtl/time_pkg.sv
// ---------------------------------------------------------------------------
// time_pkg
// Shared definitions for the front-panel time-setting controller:
//   - state_t     : edit-session FSM encoding (RUN, EDIT_HH, EDIT_MM, COMMIT)
//   - HH_MAX/MM_MAX: last legal hour / minute value
//   - *_CYC_DEF   : production cycle counts (50 MHz board clock)
//   - *_W         : counter widths derived from the production cycle counts
//   - helpers     : field wrap-around increment/decrement, edit-state test
// ---------------------------------------------------------------------------
package time_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      EDIT_HH = 2'd1,
      EDIT_MM = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [7:0] HH_MAX = 8'd23;
   localparam logic [7:0] MM_MAX = 8'd59;

   localparam int DEB_CYC_DEF     = 1_000_000;    // 20 ms
   localparam int TIMEOUT_CYC_DEF = 500_000_000;  // 10 s
   localparam int BLINK_CYC_DEF   = 25_000_000;   // 0.5 s half-period

   // Width able to hold the terminal value n-1 of a 0..n-1 counter.
   function automatic int cnt_width(input int n);
      if (n < 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Counters are sized for the production cycle counts; any parameter
   // override must not exceed the corresponding default.
   localparam int DEB_W   = cnt_width(DEB_CYC_DEF);
   localparam int TO_W    = cnt_width(TIMEOUT_CYC_DEF);
   localparam int BLINK_W = cnt_width(BLINK_CYC_DEF);

   // Step up with wrap. Anything at or above max (including an out-of-range
   // value captured from the counters) wraps to 0.
   function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
      if (v >= max) begin
         return 8'd0;
      end else begin
         return v + 8'd1;
      end
   endfunction

   // Step down with wrap. 0 wraps to max; an out-of-range value wraps to 0.
   function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
      if (v == 8'd0) begin
         return max;
      end else if (v > max) begin
         return 8'd0;
      end else begin
         return v - 8'd1;
      end
   endfunction

   function automatic logic is_edit(input state_t s);
      return (s == EDIT_HH) || (s == EDIT_MM);
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_if
// Load interface between the time-setting controller and the Cont_24/Cont_60
// counter chain.
//   cur_hh / cur_mm : live counter values (counters -> controller), binary
//   set             : one-cycle load strobe (controller -> counters)
//   s_hh / s_mm     : load values, binary
//   clr_ss          : seconds clear, coincident with set
// Modports: master = controller side, slave = counter side.
// ---------------------------------------------------------------------------
interface time_set_ctrl_if;

   logic [7:0] cur_hh;
   logic [7:0] cur_mm;
   logic       set;
   logic [7:0] s_hh;
   logic [7:0] s_mm;
   logic       clr_ss;

   modport master (
      input  cur_hh,
      input  cur_mm,
      output set,
      output s_hh,
      output s_mm,
      output clr_ss
   );

   modport slave (
      output cur_hh,
      output cur_mm,
      input  set,
      input  s_hh,
      input  s_mm,
      input  clr_ss
   );

endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Conditions one raw push-button: 2-flop synchroniser, stability counter,
// and a one-cycle pulse on the accepted 0->1 edge (no auto-repeat).
// A stable raw edge produces the pulse DEB_CYC+3 clocks later.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   key_raw   : raw key, active-high, asynchronous to clk
//   key_pulse : one-cycle press pulse (registered)
// ---------------------------------------------------------------------------
module key_debounce
   import time_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_pulse
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             stable_r;
   logic             stable_d_r;
   logic             pulse_r;
   logic [DEB_W-1:0] cnt_r;

   // Two-flop synchroniser for the asynchronous key input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= key_raw;
         sync2_r <= sync1_r;
      end
   end

   // Accept a new level only after DEB_CYC consecutive samples differ from
   // the accepted one; any sample equal to it restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= '0;
         stable_r <= 1'b0;
      end else if (sync2_r == stable_r) begin
         cnt_r    <= '0;
         stable_r <= stable_r;
      end else if (cnt_r == DEB_LAST) begin
         cnt_r    <= '0;
         stable_r <= sync2_r;
      end else begin
         cnt_r    <= cnt_r + DEB_W'(1);
         stable_r <= stable_r;
      end
   end

   // Rising-edge detect on the accepted level, registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_d_r <= 1'b0;
         pulse_r    <= 1'b0;
      end else begin
         stable_d_r <= stable_r;
         pulse_r    <= stable_r & ~stable_d_r;
      end
   end

   assign key_pulse = pulse_r;

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Front-panel time-setting controller. Three debounced keys drive an edit
// session over hours then minutes; on commit a one-cycle load strobe (set,
// with clr_ss) is issued to the counter chain. An idle session times out
// back to RUN without loading. Also drives the display's edit indicators.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   key_mode   : raw mode key (start / next field / commit)
//   key_inc    : raw increment key
//   key_dec    : raw decrement key
//   bus        : load interface (master side): cur_hh/cur_mm in,
//                set/s_hh/s_mm/clr_ss out
//   editing    : high in EDIT_HH or EDIT_MM
//   edit_field : 0 = hours selected, 1 = minutes selected
//   blink      : blink phase of the selected field
// ---------------------------------------------------------------------------
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int DEB_CYC     = DEB_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int BLINK_CYC   = BLINK_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_mode,
   input  logic              key_inc,
   input  logic              key_dec,
   time_set_ctrl_if.master   bus,
   output logic              editing,
   output logic              edit_field,
   output logic              blink
);

   localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   logic               mode_p_s;
   logic               inc_p_s;
   logic               dec_p_s;
   logic               any_p_s;

   state_t             state_r;
   state_t             state_next_s;
   logic               cur_edit_s;
   logic               next_edit_s;
   logic               to_hit_s;
   logic [7:0]         hh_next_s;
   logic [7:0]         mm_next_s;

   logic [7:0]         s_hh_r;
   logic [7:0]         s_mm_r;
   logic               set_r;
   logic               clr_ss_r;
   logic               editing_r;
   logic               edit_field_r;
   logic               blink_r;
   logic [BLINK_W-1:0] blink_cnt_r;
   logic [TO_W-1:0]    to_cnt_r;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_mode),
      .key_pulse (mode_p_s)
   );

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_inc),
      .key_pulse (inc_p_s)
   );

   key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dec (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_dec),
      .key_pulse (dec_p_s)
   );

   assign any_p_s     = mode_p_s | inc_p_s | dec_p_s;
   assign cur_edit_s  = is_edit(state_r);
   assign next_edit_s = is_edit(state_next_s);
   assign to_hit_s    = (to_cnt_r == TO_LAST);

   // Next-state and next field values. Mode beats inc/dec; inc with dec
   // cancels; any press in the same cycle as the timeout keeps the session.
   always_comb begin
      state_next_s = state_r;
      hh_next_s    = s_hh_r;
      mm_next_s    = s_mm_r;
      case (state_r)
         RUN: begin
            if (mode_p_s) begin
               hh_next_s    = bus.cur_hh;
               mm_next_s    = bus.cur_mm;
               state_next_s = EDIT_HH;
            end else begin
               state_next_s = RUN;
            end
         end
         EDIT_HH: begin
            if (mode_p_s) begin
               state_next_s = EDIT_MM;
            end else if (any_p_s) begin
               if (inc_p_s && !dec_p_s) begin
                  hh_next_s = wrap_inc(s_hh_r, HH_MAX);
               end else if (dec_p_s && !inc_p_s) begin
                  hh_next_s = wrap_dec(s_hh_r, HH_MAX);
               end else begin
                  hh_next_s = s_hh_r;
               end
            end else if (to_hit_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = EDIT_HH;
            end
         end
         EDIT_MM: begin
            if (mode_p_s) begin
               state_next_s = COMMIT;
            end else if (any_p_s) begin
               if (inc_p_s && !dec_p_s) begin
                  mm_next_s = wrap_inc(s_mm_r, MM_MAX);
               end else if (dec_p_s && !inc_p_s) begin
                  mm_next_s = wrap_dec(s_mm_r, MM_MAX);
               end else begin
                  mm_next_s = s_mm_r;
               end
            end else if (to_hit_s) begin
               state_next_s = RUN;
            end else begin
               state_next_s = EDIT_MM;
            end
         end
         COMMIT: begin
            state_next_s = RUN;
         end
         default: begin
            state_next_s = RUN;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Field values and status outputs, registered from the next state so they
   // line up with the state they describe (set/clr_ss high during COMMIT).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_hh_r       <= 8'd0;
         s_mm_r       <= 8'd0;
         set_r        <= 1'b0;
         clr_ss_r     <= 1'b0;
         editing_r    <= 1'b0;
         edit_field_r <= 1'b0;
      end else begin
         s_hh_r       <= hh_next_s;
         s_mm_r       <= mm_next_s;
         set_r        <= (state_next_s == COMMIT);
         clr_ss_r     <= (state_next_s == COMMIT);
         editing_r    <= next_edit_s;
         edit_field_r <= (state_next_s == EDIT_MM);
      end
   end

   // Inactivity timer: cleared on any press and on entering an edit state,
   // counts only while staying in an edit state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_r <= '0;
      end else if (!next_edit_s || !cur_edit_s || any_p_s) begin
         to_cnt_r <= '0;
      end else begin
         to_cnt_r <= to_cnt_r + TO_W'(1);
      end
   end

   // Blink generator: idle (0) outside edit states, starts dark on session
   // entry, restarts lit on every press so the adjusted field stays visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b0;
      end else if (!next_edit_s || !cur_edit_s) begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b0;
      end else if (any_p_s) begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b1;
      end else if (blink_cnt_r == BLINK_LAST) begin
         blink_cnt_r <= '0;
         blink_r     <= ~blink_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
         blink_r     <= blink_r;
      end
   end

   assign bus.set    = set_r;
   assign bus.clr_ss = clr_ss_r;
   assign bus.s_hh   = s_hh_r;
   assign bus.s_mm   = s_mm_r;
   assign editing    = editing_r;
   assign edit_field = edit_field_r;
   assign blink      = blink_r;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-panel time-setting controller: the writer side of the hour/minute counters' load interface (set strobe plus load value). It turns three raw push-buttons into an edit session over hours then minutes, holds the edited values and issues a one-cycle load strobe on commit. It sits between the board keys and the Cont_24/Cont_60 counter chain; it also drives the display's blink/edit indicators.

Parameters:
DEB_CYC, 1_000_000, clk cycles a key must be stable before it is accepted (20 ms at 50 MHz)
TIMEOUT_CYC, 500_000_000, idle clk cycles in an edit state before the session is aborted (10 s)
BLINK_CYC, 25_000_000, clk cycles per half-period of the blink output

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
key_mode  in  1  raw mode key, active-high, asynchronous to clk
key_inc  in  1  raw increment key, active-high
key_dec  in  1  raw decrement key, active-high
cur_hh  in  8  live hour count, binary 0..23
cur_mm  in  8  live minute count, binary 0..59
set  out  1  load strobe to the counters; high for exactly one clk
s_hh  out  8  hour load value, binary
s_mm  out  8  minute load value, binary
clr_ss  out  1  seconds clear; coincident with set
editing  out  1  high while in EDIT_HH or EDIT_MM
edit_field  out  1  0 = hours selected, 1 = minutes selected
blink  out  1  blink phase for the selected display field

Behaviour:
- Reset (async, rst=1): state RUN; set=0, clr_ss=0, s_hh=0, s_mm=0, editing=0, edit_field=0, blink=0; debounce, timeout and blink counters=0.
- Key conditioning: each key passes through a 2-flop synchroniser, then a stability counter. A key is accepted after DEB_CYC consecutive equal samples. A one-cycle press pulse is generated on the accepted 0->1 edge only. There is no auto-repeat. Latency from a stable raw edge to the pulse is DEB_CYC+3 clk.
- FSM states: RUN, EDIT_HH, EDIT_MM, COMMIT.
- RUN: on a mode pulse, load s_hh<=cur_hh and s_mm<=cur_mm, then go to EDIT_HH. inc/dec pulses are ignored.
- EDIT_HH: an inc pulse sets s_hh<=s_hh+1, wrapping 23->0. A dec pulse sets s_hh<=s_hh-1, wrapping 0->23. A mode pulse goes to EDIT_MM.
- EDIT_MM: same as EDIT_HH on s_mm, wrapping 59->0 and 0->59. A mode pulse goes to COMMIT.
- COMMIT: lasts one cycle. set=1 and clr_ss=1 are driven from flops; s_hh/s_mm are stable and unchanged. Next state is RUN.
- set/clr_ss are registered outputs, high only during the COMMIT cycle. s_hh/s_mm hold their values after commit until the next session loads them.
- Simultaneous pulses in one cycle:
  - mode with inc or dec: mode wins and the value is unchanged.
  - inc with dec: no change.
- Timeout counter:
  - Cleared on any press pulse and on entry to an edit state; counts while in EDIT_HH or EDIT_MM.
  - When it reaches TIMEOUT_CYC-1, the FSM goes to RUN with no set pulse; edited values are discarded.
- blink: a free counter runs only while editing and toggles blink every BLINK_CYC cycles. On entry to RUN both the counter and blink are forced to 0. Each press pulse in an edit state restarts the counter with blink=1, so the field stays visible while being adjusted.
- editing = (state==EDIT_HH or state==EDIT_MM). edit_field = (state==EDIT_MM).
- Reset mid-edit or mid-COMMIT: immediate return to reset values; no set pulse may escape.
- Out-of-range cur_hh or cur_mm captured at session start: the first inc or dec wraps to 0. No clamping is done on capture.

Decomposition:
- Shared package time_pkg holds:
  - the state encoding constants (RUN=2'd0, EDIT_HH=2'd1, EDIT_MM=2'd2, COMMIT=2'd3);
  - HH_MAX=8'd23 and MM_MAX=8'd59;
  - the counter widths, derived by $clog2 of the parameters.
- One sub-module, key_debounce (parameter DEB_CYC; ports clk, rst, key_raw, key_pulse), instantiated three times.

Test Plan (bench overrides DEB_CYC=4, TIMEOUT_CYC=100, BLINK_CYC=8):
- Bounce filtering: key_inc toggling every 2 clk for 20 clk, then held high. Exactly one press pulse, 7 clk after the final rising edge.
- Full set session: cur_hh=22, cur_mm=58. Press mode, inc x3, mode, inc x2, mode. Required response:
  - s_hh=1 and s_mm=0;
  - set and clr_ss high for exactly 1 clk;
  - editing=0 afterwards.
- Decrement wrap: cur_hh=0, cur_mm=0. Press mode, dec, mode, dec, mode. Required: s_hh=23, s_mm=59, one set pulse.
- Timeout abort: enter EDIT_MM and press inc once, then press nothing for 100 clk. Required: state RUN, set never asserted, editing=0.
- Simultaneous events: in EDIT_HH, drive inc and dec pulses in the same cycle, then mode and inc together. Required: s_hh unchanged both times and the state advances to EDIT_MM.
- Reset during COMMIT: assert rst in the COMMIT cycle. Required: set=0 within the same cycle (async) and all outputs at their reset values.
